// File: rtl/anton_neopixel_pkg.sv
// Shared constants for the NeoPixel loader and transmitter: register map,
// control bit positions and loader FSM encodings.
package anton_neopixel_pkg;

  localparam logic [13:0] ADDR_REG_MAX_L = 14'h2000;
  localparam logic [13:0] ADDR_REG_MAX_H = 14'h2001;
  localparam logic [13:0] ADDR_REG_CTRL  = 14'h2002;
  localparam logic [13:0] ADDR_REG_STATE = 14'h2003;

  localparam int CTRL_INIT  = 0;
  localparam int CTRL_LIMIT = 1;
  localparam int CTRL_RUN   = 2;
  localparam int CTRL_LOOP  = 3;
  localparam int CTRL_BIT32 = 4;

  localparam logic [7:0] CTRL_INIT_WORD = 8'(1 << CTRL_INIT);
  localparam logic [7:0] CTRL_RUN_MASK  = 8'(1 << CTRL_RUN);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_INIT      = 4'd1;
  localparam logic [3:0] ST_INIT_WAIT = 4'd2;
  localparam logic [3:0] ST_LOAD      = 4'd3;
  localparam logic [3:0] ST_WR_MAXL   = 4'd4;
  localparam logic [3:0] ST_WR_MAXH   = 4'd5;
  localparam logic [3:0] ST_WR_CTRL   = 4'd6;
  localparam logic [3:0] ST_POLL      = 4'd7;
  localparam logic [3:0] ST_POLL_CHK  = 4'd8;
  localparam logic [3:0] ST_DONE      = 4'd9;

  function automatic logic [7:0] ctrl_run_word(input logic bit32, input logic loop);
    logic [7:0] w;
    w             = '0;
    w[CTRL_BIT32] = bit32;
    w[CTRL_LOOP]  = loop;
    w[CTRL_RUN]   = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/anton_bus_master_port.sv
// Registers a one-cycle write/read request onto the transmitter byte bus and
// flags when the read data returned by the transmitter is valid.
module anton_bus_master_port (
  input  logic        busClk,
  input  logic        busReset,
  input  logic        wrReq_i,
  input  logic        rdReq_i,
  input  logic [13:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic [13:0] busAddr_o,
  output logic [7:0]  busDataIn_o,
  output logic        busWrite_o,
  output logic        busRead_o,
  input  logic [7:0]  busDataOut_i,
  output logic        rdValid_o,
  output logic [7:0]  rdData_o
);

  logic [13:0] addr_q;
  logic [7:0]  data_q;
  logic        wr_q, rd_q, rdv_q;

  always_ff @(posedge busClk) begin
    if (busReset) begin
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      rdv_q  <= 1'b0;
    end else begin
      wr_q  <= wrReq_i;
      // Writes win so the two strobes can never overlap on the bus.
      rd_q  <= rdReq_i && !wrReq_i;
      rdv_q <= rd_q;
      if (wrReq_i || rdReq_i) addr_q <= addr_i;
      if (wrReq_i) data_q <= wdata_i;
    end
  end

  assign busAddr_o   = addr_q;
  assign busDataIn_o = data_q;
  assign busWrite_o  = wr_q;
  assign busRead_o   = rd_q;
  assign rdValid_o   = rdv_q;
  assign rdData_o    = busDataOut_i;

endmodule

// File: rtl/anton_neopixel_stream_loader.sv
// Loads a framed byte stream into the NeoPixel transmitter buffer, programs
// length/control, and in one-shot mode polls until the run bit clears.
module anton_neopixel_stream_loader
  import anton_neopixel_pkg::*;
#(
  parameter int PIXELS_MAX    = 66,
  parameter int POLL_INTERVAL = 64
) (
  input  logic        busClk,
  input  logic        busReset,
  input  logic [7:0]  streamData,
  input  logic        streamValid,
  input  logic        streamLast,
  output logic        streamReady,
  input  logic        cfg32bit,
  input  logic        cfgLoop,
  output logic [13:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut,
  output logic        busy,
  output logic        done,
  output logic        errOverflow
);

  localparam int CNT_BITS = $clog2(PIXELS_MAX + 1);
  localparam int TMR_BITS = $clog2(POLL_INTERVAL + 1);

  logic [3:0]          state_q, state_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [TMR_BITS-1:0] tmr_q, tmr_d;
  logic                bit32_q, bit32_d, loop_q, loop_d;
  logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic                wr_req, rd_req, rd_valid, run_seen;
  logic [13:0]         req_addr;
  logic [7:0]          req_data, rd_data;
  logic [15:0]         count_ext;

  assign count_ext = 16'(count_q);
  assign run_seen  = |(rd_data & CTRL_RUN_MASK);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tmr_d    = tmr_q;
    bit32_d  = bit32_q;
    loop_d   = loop_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    req_addr = ADDR_REG_CTRL;
    req_data = '0;
    case (state_q)
      ST_IDLE: if (streamValid) begin
        bit32_d = cfg32bit;
        loop_d  = cfgLoop;
        ovf_d   = 1'b0;
        count_d = '0;
        busy_d  = 1'b1;
        state_d = ST_INIT;
      end
      ST_INIT: begin
        wr_req   = 1'b1;
        req_data = CTRL_INIT_WORD;
        tmr_d    = '0;
        state_d  = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        tmr_d = tmr_q + TMR_BITS'(1);
        if (tmr_q == TMR_BITS'(1)) state_d = ST_LOAD;
      end
      ST_LOAD: if (streamValid) begin
        if (count_q < CNT_BITS'(PIXELS_MAX)) begin
          wr_req   = 1'b1;
          req_addr = {1'b0, 13'(count_q)};
          req_data = streamData;
          count_d  = count_q + CNT_BITS'(1);
        end else begin
          ovf_d = 1'b1;
        end
        if (streamLast) state_d = ST_WR_MAXL;
      end
      ST_WR_MAXL: begin
        wr_req   = 1'b1;
        req_addr = ADDR_REG_MAX_L;
        req_data = count_ext[7:0];
        state_d  = ST_WR_MAXH;
      end
      ST_WR_MAXH: begin
        wr_req   = 1'b1;
        req_addr = ADDR_REG_MAX_H;
        req_data = count_ext[15:8];
        state_d  = ST_WR_CTRL;
      end
      ST_WR_CTRL: begin
        wr_req   = 1'b1;
        req_data = ctrl_run_word(bit32_q, loop_q);
        tmr_d    = '0;
        state_d  = loop_q ? ST_DONE : ST_POLL;
      end
      ST_POLL: begin
        if (tmr_q == TMR_BITS'(POLL_INTERVAL)) begin
          rd_req  = 1'b1;
          state_d = ST_POLL_CHK;
        end else begin
          tmr_d = tmr_q + TMR_BITS'(1);
        end
      end
      // The check cycle counts towards the next interval, keeping reads
      // POLL_INTERVAL+2 cycles apart.
      ST_POLL_CHK: if (rd_valid) begin
        if (run_seen) begin
          tmr_d   = TMR_BITS'(1);
          state_d = ST_POLL;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // One-shot frames already flagged done when the clear run bit arrived.
        if (loop_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge busClk) begin
    if (busReset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tmr_q   <= '0;
      bit32_q <= 1'b0;
      loop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tmr_q   <= tmr_d;
      bit32_q <= bit32_d;
      loop_q  <= loop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  anton_bus_master_port u_port (
    .busClk      (busClk),
    .busReset    (busReset),
    .wrReq_i     (wr_req),
    .rdReq_i     (rd_req),
    .addr_i      (req_addr),
    .wdata_i     (req_data),
    .busAddr_o   (busAddr),
    .busDataIn_o (busDataIn),
    .busWrite_o  (busWrite),
    .busRead_o   (busRead),
    .busDataOut_i(busDataOut),
    .rdValid_o   (rd_valid),
    .rdData_o    (rd_data)
  );

  assign streamReady = (state_q == ST_LOAD);
  assign busy        = busy_q;
  assign done        = done_q;
  assign errOverflow = ovf_q;

endmodule

// File: tb/tb_anton_neopixel_stream_loader.sv
// Self-checking bench for anton_neopixel_stream_loader: table vectors, random
// frames and hand sequences against a transaction-level reference model.
module tb_anton_neopixel_stream_loader;

  localparam int PMAX = 66;
  localparam int PI   = 4;

  logic        busClk = 1'b0;
  logic        busReset;
  logic [7:0]  streamData;
  logic        streamValid, streamLast, streamReady;
  logic        cfg32bit, cfgLoop;
  logic [13:0] busAddr;
  logic [7:0]  busDataIn, busDataOut;
  logic        busWrite, busRead, busy, done, errOverflow;

  anton_neopixel_stream_loader #(.PIXELS_MAX(PMAX), .POLL_INTERVAL(PI)) dut (
    .busClk(busClk), .busReset(busReset), .streamData(streamData),
    .streamValid(streamValid), .streamLast(streamLast), .streamReady(streamReady),
    .cfg32bit(cfg32bit), .cfgLoop(cfgLoop), .busAddr(busAddr), .busDataIn(busDataIn),
    .busWrite(busWrite), .busRead(busRead), .busDataOut(busDataOut), .busy(busy),
    .done(done), .errOverflow(errOverflow)
  );

  always #5 busClk = ~busClk;

  int cyc = 0;
  always @(posedge busClk) cyc <= cyc + 1;

  // Transmitter stand-in: reports run=1 until rd_count reaches run_limit.
  int rd_count = 0;
  int run_limit = 0;
  always @(posedge busClk) begin
    if (busReset) busDataOut <= 8'h00;
    else if (busRead) begin
      rd_count   <= rd_count + 1;
      busDataOut <= (rd_count < run_limit) ? 8'h1D : 8'h19;
    end
  end

  typedef struct { int cyc; int addr; int data; } wr_t;
  wr_t wr_log[$];
  int  rd_log[$];
  int  done_log[$];
  int  both_hi = 0;
  int  rd_bad_addr = 0;
  always @(negedge busClk) begin
    if (busWrite) wr_log.push_back('{cyc, int'(busAddr), int'(busDataIn)});
    if (busRead) begin
      rd_log.push_back(cyc);
      if (busAddr != 14'h2002) rd_bad_addr = rd_bad_addr + 1;
    end
    if (done) done_log.push_back(cyc);
    if (busWrite && busRead) both_hi = both_hi + 1;
  end

  int passed = 0, total = 0;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  logic [7:0] frm[$];
  int acc[$];
  int t_start, n_acc, wr_base, rd_base, done_base;
  logic ovf_at_start, busy_at_start;

  task automatic run_frame(input bit lp, input bit b32, input int run_hi, input int gap);
    int n = frm.size();
    int i = 0, guard = 0;
    bit tog = 1'b1, v;
    wr_base = wr_log.size(); rd_base = rd_log.size(); done_base = done_log.size();
    acc.delete();
    run_limit = rd_count + run_hi;
    @(negedge busClk);
    t_start = cyc;
    cfg32bit = b32; cfgLoop = lp;
    ovf_at_start = 1'b1; busy_at_start = 1'b0;
    while (i < n && guard < 3000) begin
      if (cyc == t_start + 1) begin
        ovf_at_start = errOverflow; busy_at_start = busy;
        cfg32bit = !b32; cfgLoop = !lp;
      end
      if (!streamReady || gap == 0) v = 1'b1;
      else if (gap == 1) begin v = tog; tog = !tog; end
      else v = ($urandom_range(0, 2) != 0);
      streamValid = v; streamData = frm[i]; streamLast = (i == n - 1);
      if (v && streamReady) begin acc.push_back(cyc); i++; end
      @(negedge busClk); guard++;
    end
    streamValid = 1'b0; streamLast = 1'b0;
    n_acc = i;
    guard = 0;
    while (!done && guard < 400) begin @(negedge busClk); guard++; end
    if (!done) check("done_timeout", 0, 1);
    @(negedge busClk);
  endtask

  task automatic verify(input string tag, input bit lp, input bit b32, input int run_hi, input int gap);
    wr_t exp[$];
    int n = frm.size();
    int m = (n > PMAX) ? PMAX : n;
    int nw, nr, L, bad, fb, e;
    exp.push_back('{0, 'h2002, 1});
    for (int k = 0; k < m; k++) exp.push_back('{0, k, int'(frm[k])});
    exp.push_back('{0, 'h2000, m % 256});
    exp.push_back('{0, 'h2001, m / 256});
    exp.push_back('{0, 'h2002, (b32 ? 16 : 0) + (lp ? 8 : 0) + 4});
    check({tag, " accepted"}, n_acc, n);
    nw = wr_log.size() - wr_base;
    check({tag, " nwrites"}, nw, exp.size());
    check({tag, " ovf_cleared_at_start"}, int'(ovf_at_start), 0);
    check({tag, " busy_at_start"}, int'(busy_at_start), 1);
    check({tag, " errOverflow"}, int'(errOverflow), (n > PMAX) ? 1 : 0);
    check({tag, " busy_after"}, int'(busy), 0);
    check({tag, " done_pulses"}, done_log.size() - done_base, 1);
    if (nw == exp.size() && n_acc == n && n > 0) begin
      bad = 0; fb = -1;
      for (int k = 0; k < nw; k++)
        if (wr_log[wr_base+k].addr != exp[k].addr || wr_log[wr_base+k].data != exp[k].data) begin
          bad++; if (fb < 0) fb = k;
        end
      check({tag, " write_content_errors"}, bad, 0);
      if (fb >= 0) check({tag, " first_bad_write_addr"}, wr_log[wr_base+fb].addr, exp[fb].addr);
      L = acc[n-1];
      check({tag, " init_cycle"}, wr_log[wr_base].cyc - t_start, 2);
      if (gap != 2) check({tag, " first_accept"}, acc[0] - t_start, 4);
      bad = 0;
      for (int k = 0; k < m; k++) if (wr_log[wr_base+1+k].cyc != acc[k] + 1) bad++;
      check({tag, " buf_write_latency_errors"}, bad, 0);
      check({tag, " maxl_cycle"}, wr_log[wr_base+nw-3].cyc - L, 2);
      check({tag, " maxh_cycle"}, wr_log[wr_base+nw-2].cyc - L, 3);
      check({tag, " ctrl_cycle"}, wr_log[wr_base+nw-1].cyc - L, 4);
      nr = rd_log.size() - rd_base;
      check({tag, " nreads"}, nr, lp ? 0 : run_hi + 1);
      if (done_log.size() > done_base) begin
        if (lp) check({tag, " done_cycle"}, done_log[done_base] - L, 5);
        else if (nr > 0) begin
          check({tag, " first_read"}, rd_log[rd_base] - L, 5 + PI);
          bad = 0;
          for (int k = 1; k < nr; k++) if (rd_log[rd_base+k] - rd_log[rd_base+k-1] != 6) bad++;
          check({tag, " read_spacing_errors"}, bad, 0);
          check({tag, " done_after_read"}, done_log[done_base] - rd_log[rd_base+nr-1], 2);
        end
      end
    end
  endtask

  typedef struct { int len; bit lp; bit b32; int run_hi; int gap; int exp_max; bit exp_ovf; int exp_reads; } vec_t;
  vec_t vecs[6];

  initial begin
    int guard, i, nw;
    vecs[0] = '{3,  1'b1, 1'b0, 0, 0, 3,  1'b0, 0};
    vecs[1] = '{3,  1'b0, 1'b0, 2, 0, 3,  1'b0, 3};
    vecs[2] = '{70, 1'b1, 1'b0, 0, 0, 66, 1'b1, 0};
    vecs[3] = '{12, 1'b1, 1'b1, 0, 1, 12, 1'b0, 0};
    vecs[4] = '{1,  1'b0, 1'b1, 0, 0, 1,  1'b0, 1};
    vecs[5] = '{66, 1'b1, 1'b0, 1, 2, 66, 1'b0, 0};

    busReset = 1'b1; streamValid = 1'b0; streamLast = 1'b0; streamData = 8'h00;
    cfg32bit = 1'b0; cfgLoop = 1'b0;
    repeat (3) @(negedge busClk);
    check("reset_outputs", int'({busAddr, busDataIn, busWrite, busRead, busy, done, errOverflow, streamReady}), 0);
    busReset = 1'b0;
    @(negedge busClk);

    for (int v = 0; v < 6; v++) begin
      frm.delete();
      if (v < 2) frm = '{8'hE0, 8'h1C, 8'h03};
      else for (int k = 0; k < vecs[v].len; k++) frm.push_back(8'($urandom));
      run_frame(vecs[v].lp, vecs[v].b32, vecs[v].run_hi, vecs[v].gap);
      verify($sformatf("vec%0d", v), vecs[v].lp, vecs[v].b32, vecs[v].run_hi, vecs[v].gap);
      nw = wr_log.size() - wr_base;
      if (nw >= 3) check($sformatf("vec%0d max_written", v), wr_log[wr_base+nw-3].data, vecs[v].exp_max);
      check($sformatf("vec%0d table_ovf", v), int'(errOverflow), int'(vecs[v].exp_ovf));
      check($sformatf("vec%0d table_reads", v), rd_log.size() - rd_base, vecs[v].exp_reads);
    end

    for (int r = 0; r < 4; r++) begin
      bit lp, b32;
      int rh;
      frm.delete();
      for (int k = 0; k < int'($urandom_range(1, 72)); k++) frm.push_back(8'($urandom));
      lp = 1'($urandom_range(0, 1)); b32 = 1'($urandom_range(0, 1)); rh = $urandom_range(0, 2);
      run_frame(lp, b32, rh, 2);
      verify($sformatf("rand%0d", r), lp, b32, rh, 2);
    end

    // Reset one cycle after the 10th byte is accepted.
    frm.delete();
    for (int k = 0; k < 20; k++) frm.push_back(8'($urandom));
    cfg32bit = 1'b0; cfgLoop = 1'b1;
    i = 0; guard = 0;
    @(negedge busClk);
    while (i < 10 && guard < 100) begin
      streamValid = 1'b1; streamData = frm[i]; streamLast = 1'b0;
      if (streamReady) i++;
      @(negedge busClk); guard++;
    end
    check("rst_seq accepted", i, 10);
    busReset = 1'b1; streamValid = 1'b0;
    @(negedge busClk);
    check("rst_seq outputs_zero", int'({busAddr, busDataIn, busWrite, busRead, busy, done, errOverflow, streamReady}), 0);
    busReset = 1'b0;
    frm = '{8'hA5, 8'h5A};
    run_frame(1'b0, 1'b0, 0, 0);
    verify("after_reset", 1'b0, 1'b0, 0, 0);

    check("strobes_never_overlap", both_hi, 0);
    check("read_address_errors", rd_bad_addr, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
